lutram_access_arbiter: RTL and testbench

- Front-end controller for one single-port LUTRAM instance (1-cycle registered read, synchronous write, one access per cycle).
- Arbitrates a read-request channel and a write-request channel onto the storage's single access port.
- Returns read data to the requester over a valid/ready response channel with backpressure.
- Sits directly upstream of the storage and consumes its read output.

---
 rtl/lutram_access_arbiter.sv | 104 ++++++++++
 tb/tb_lutram_access_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lutram_access_arbiter.sv
// Purpose: arbitrates read and write requests onto a single-port LUTRAM and returns read data.
// Latency: a read granted in cycle N presents its response from cycle N+1; writes commit in the grant cycle.
// Backpressure: a stalled response blocks new read grants; writes keep flowing every cycle.
module lutram_access_arbiter #(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
  parameter int NUMBER_SETS                 = 64,
  parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS)
) (
  input  logic                                   clk_in,
  input  logic                                   reset_n_in,
  input  logic                                   rd_req_valid_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       rd_req_addr_in,
  output logic                                   rd_req_ready_out,
  input  logic                                   wr_req_valid_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       wr_req_addr_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] wr_req_data_in,
  output logic                                   wr_req_ready_out,
  output logic                                   rd_rsp_valid_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] rd_rsp_data_out,
  input  logic                                   rd_rsp_ready_in,
  output logic                                   access_en_out,
  output logic                                   write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]       access_set_addr_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] write_element_out,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] read_element_in
);

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_e;

  grant_e r_last_grant;
  grant_e w_last_grant_nxt;
  logic   r_rsp_pending;
  logic   w_rsp_pending_nxt;
  logic   w_rd_ok;
  logic   w_wr_ok;
  logic   w_rd_grant;
  logic   w_wr_grant;
  logic   w_any_grant;
  logic   w_rsp_handshake;

  // A read may only issue if there is no response stalled in front of it.
  assign w_rd_ok         = rd_req_valid_in & (~r_rsp_pending | rd_rsp_ready_in);
  assign w_wr_ok         = wr_req_valid_in;
  assign w_any_grant     = w_rd_grant | w_wr_grant;
  assign w_rsp_handshake = r_rsp_pending & rd_rsp_ready_in;

  // Round-robin grant plus next-state for the arbitration history and response flag.
  always_comb begin
    w_rd_grant        = 1'b0;
    w_wr_grant        = 1'b0;
    w_last_grant_nxt  = r_last_grant;
    w_rsp_pending_nxt = r_rsp_pending;
    // Grants are held off while reset is asserted so nothing reaches the storage.
    if (reset_n_in) begin
      if (w_rd_ok && w_wr_ok) begin
        if (r_last_grant == GRANT_WRITE) w_rd_grant = 1'b1;
        else                             w_wr_grant = 1'b1;
      end else if (w_rd_ok) begin
        w_rd_grant = 1'b1;
      end else if (w_wr_ok) begin
        w_wr_grant = 1'b1;
      end
    end
    if (w_rd_grant) w_last_grant_nxt = GRANT_READ;
    if (w_wr_grant) w_last_grant_nxt = GRANT_WRITE;
    // A new read grant wins over a same-cycle handshake, giving one read per cycle.
    if (w_rd_grant)           w_rsp_pending_nxt = 1'b1;
    else if (w_rsp_handshake) w_rsp_pending_nxt = 1'b0;
  end

  // Arbitration history and outstanding-response state.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_last_grant  <= GRANT_WRITE;
      r_rsp_pending <= 1'b0;
    end else begin
      r_last_grant  <= w_last_grant_nxt;
      r_rsp_pending <= w_rsp_pending_nxt;
    end
  end

  // Request-side handshakes and storage drive follow the grant directly.
  always_comb begin
    rd_req_ready_out    = w_rd_grant;
    wr_req_ready_out    = w_wr_grant;
    access_en_out       = w_any_grant;
    write_en_out        = w_wr_grant;
    access_set_addr_out = '0;
    write_element_out   = '0;
    if (w_rd_grant) access_set_addr_out = rd_req_addr_in;
    if (w_wr_grant) access_set_addr_out = wr_req_addr_in;
    if (w_any_grant) write_element_out = wr_req_data_in;
  end

  // Storage read output only changes on reads, so it stays stable under a stall.
  always_comb begin
    rd_rsp_valid_out = r_rsp_pending;
    rd_rsp_data_out  = r_rsp_pending ? read_element_in : '0;
  end

endmodule

// File: tb/tb_lutram_access_arbiter.sv
module tb_lutram_access_arbiter;
  localparam int DW = 64;
  localparam int NS = 64;
  localparam int AW = $clog2(NS);

  logic          clk_in = 1'b0;
  logic          reset_n_in;
  logic          rd_req_valid_in;
  logic [AW-1:0] rd_req_addr_in;
  logic          rd_req_ready_out;
  logic          wr_req_valid_in;
  logic [AW-1:0] wr_req_addr_in;
  logic [DW-1:0] wr_req_data_in;
  logic          wr_req_ready_out;
  logic          rd_rsp_valid_out;
  logic [DW-1:0] rd_rsp_data_out;
  logic          rd_rsp_ready_in;
  logic          access_en_out;
  logic          write_en_out;
  logic [AW-1:0] access_set_addr_out;
  logic [DW-1:0] write_element_out;
  logic [DW-1:0] read_element_in;

  int checks = 0;
  int errors = 0;
  int rsp_count;

  logic [DW-1:0] mem [0:NS-1];

  lutram_access_arbiter #(
    .SINGLE_ELEMENT_SIZE_IN_BITS(DW),
    .NUMBER_SETS(NS)
  ) dut (
    .clk_in(clk_in),
    .reset_n_in(reset_n_in),
    .rd_req_valid_in(rd_req_valid_in),
    .rd_req_addr_in(rd_req_addr_in),
    .rd_req_ready_out(rd_req_ready_out),
    .wr_req_valid_in(wr_req_valid_in),
    .wr_req_addr_in(wr_req_addr_in),
    .wr_req_data_in(wr_req_data_in),
    .wr_req_ready_out(wr_req_ready_out),
    .rd_rsp_valid_out(rd_rsp_valid_out),
    .rd_rsp_data_out(rd_rsp_data_out),
    .rd_rsp_ready_in(rd_rsp_ready_in),
    .access_en_out(access_en_out),
    .write_en_out(write_en_out),
    .access_set_addr_out(access_set_addr_out),
    .write_element_out(write_element_out),
    .read_element_in(read_element_in)
  );

  always #5 clk_in = ~clk_in;

  // Single-port LUTRAM model: registered read, output only updates on reads.
  // Contents are preloaded with addr*0x11 while reset is held.
  always @(posedge clk_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < NS; i++) mem[i] <= 64'(i) * 64'h11;
      read_element_in <= '0;
    end else if (access_en_out) begin
      if (write_en_out) mem[access_set_addr_out] <= write_element_out;
      else              read_element_in <= mem[access_set_addr_out];
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    // Reset with both channels requesting.
    reset_n_in      = 1'b0;
    rd_req_valid_in = 1'b1;
    rd_req_addr_in  = 6'd1;
    wr_req_valid_in = 1'b1;
    wr_req_addr_in  = 6'd10;
    wr_req_data_in  = 64'hAA;
    rd_rsp_ready_in = 1'b1;
    #2;
    check("rst_rsp_valid", rd_rsp_valid_out, 0);
    check("rst_rsp_data", rd_rsp_data_out, 0);
    check("rst_access_en", access_en_out, 0);
    check("rst_write_en", write_en_out, 0);
    check("rst_addr", access_set_addr_out, 0);
    check("rst_wdata", write_element_out, 0);
    check("rst_rd_ready", rd_req_ready_out, 0);
    check("rst_wr_ready", wr_req_ready_out, 0);
    @(posedge clk_in);
    @(posedge clk_in);
    #2;
    reset_n_in = 1'b1;
    #1;
    // First contention after reset goes to read.
    check("first_rd_ready", rd_req_ready_out, 1);
    check("first_wr_ready", wr_req_ready_out, 0);
    check("first_addr", access_set_addr_out, 6'd1);
    check("first_write_en", write_en_out, 0);
    tick();
    rd_req_valid_in = 1'b0;
    wr_req_valid_in = 1'b0;
    #1;
    check("first_rsp_valid", rd_rsp_valid_out, 1);
    check("first_rsp_data", rd_rsp_data_out, 64'h11);
    check("idle_access_en", access_en_out, 0);
    check("idle_addr", access_set_addr_out, 0);
    tick();
    check("first_rsp_done", rd_rsp_valid_out, 0);

    // Streaming reads of addresses 0..7, one per cycle.
    for (int k = 0; k < 8; k++) begin
      rd_req_valid_in = 1'b1;
      rd_req_addr_in  = 6'(k);
      #1;
      check("stream_rd_ready", rd_req_ready_out, 1);
      if (k > 0) begin
        check("stream_rsp_valid", rd_rsp_valid_out, 1);
        check("stream_rsp_data", rd_rsp_data_out, 64'(k - 1) * 64'h11);
      end
      tick();
    end
    rd_req_valid_in = 1'b0;
    #1;
    check("stream_last_valid", rd_rsp_valid_out, 1);
    check("stream_last_data", rd_rsp_data_out, 64'h77);
    tick();
    check("stream_done", rd_rsp_valid_out, 0);

    // Write addr 5 then read it back the next cycle.
    wr_req_valid_in = 1'b1;
    wr_req_addr_in  = 6'd5;
    wr_req_data_in  = 64'hDEAD_BEEF_0123_4567;
    #1;
    check("wr_access_en", access_en_out, 1);
    check("wr_write_en", write_en_out, 1);
    check("wr_ready", wr_req_ready_out, 1);
    check("wr_addr", access_set_addr_out, 6'd5);
    check("wr_wdata", write_element_out, 64'hDEAD_BEEF_0123_4567);
    tick();
    wr_req_valid_in = 1'b0;
    rd_req_valid_in = 1'b1;
    rd_req_addr_in  = 6'd5;
    #1;
    check("rd5_access_en", access_en_out, 1);
    check("rd5_write_en", write_en_out, 0);
    check("rd5_ready", rd_req_ready_out, 1);
    check("rd5_rsp_valid", rd_rsp_valid_out, 0);
    tick();
    rd_req_valid_in = 1'b0;
    #1;
    check("rd5_rsp_valid2", rd_rsp_valid_out, 1);
    check("rd5_rsp_data", rd_rsp_data_out, 64'hDEAD_BEEF_0123_4567);
    tick();

    // Lone write so the last grant is a write before contention.
    wr_req_valid_in = 1'b1;
    wr_req_addr_in  = 6'd8;
    wr_req_data_in  = 64'h88;
    #1;
    check("pre_wr_ready", wr_req_ready_out, 1);
    tick();

    // Contention for 6 cycles: R,W,R,W,R,W with 3 responses.
    rsp_count       = 0;
    rd_req_addr_in  = 6'd2;
    wr_req_addr_in  = 6'd20;
    for (int c = 0; c < 6; c++) begin
      rd_req_valid_in = 1'b1;
      wr_req_valid_in = 1'b1;
      wr_req_data_in  = 64'h1000 + 64'(c);
      #1;
      check("cont_rd_ready", rd_req_ready_out, (c % 2) == 0);
      check("cont_wr_ready", wr_req_ready_out, (c % 2) == 1);
      check("cont_rsp_valid", rd_rsp_valid_out, (c % 2) == 1);
      if (c % 2 == 1) check("cont_rsp_data", rd_rsp_data_out, 64'h22);
      if (rd_rsp_valid_out && rd_rsp_ready_in) rsp_count++;
      tick();
    end
    rd_req_valid_in = 1'b0;
    wr_req_valid_in = 1'b0;
    #1;
    check("cont_rsp_count", rsp_count, 3);
    check("cont_after_valid", rd_rsp_valid_out, 0);

    // Backpressure: read addr 3, then stall 4 cycles with both channels valid.
    rd_req_valid_in = 1'b1;
    rd_req_addr_in  = 6'd3;
    #1;
    check("bp_rd_ready", rd_req_ready_out, 1);
    tick();
    rd_rsp_ready_in = 1'b0;
    wr_req_valid_in = 1'b1;
    wr_req_addr_in  = 6'd30;
    for (int s = 0; s < 4; s++) begin
      wr_req_data_in = 64'h3000 + 64'(s);
      #1;
      check("bp_stall_rd_ready", rd_req_ready_out, 0);
      check("bp_stall_wr_ready", wr_req_ready_out, 1);
      check("bp_stall_write_en", write_en_out, 1);
      check("bp_stall_valid", rd_rsp_valid_out, 1);
      check("bp_stall_data", rd_rsp_data_out, 64'h33);
      tick();
    end
    rd_rsp_ready_in = 1'b1;
    rd_req_valid_in = 1'b0;
    wr_req_valid_in = 1'b0;
    #1;
    check("bp_release_valid", rd_rsp_valid_out, 1);
    check("bp_release_data", rd_rsp_data_out, 64'h33);
    tick();
    check("bp_once", rd_rsp_valid_out, 0);

    // Async reset mid-stall.
    rd_req_valid_in = 1'b1;
    rd_req_addr_in  = 6'd4;
    #1;
    tick();
    rd_req_valid_in = 1'b0;
    rd_rsp_ready_in = 1'b0;
    #1;
    check("ar_pending", rd_rsp_valid_out, 1);
    check("ar_pending_data", rd_rsp_data_out, 64'h44);
    reset_n_in = 1'b0;
    #1;
    check("ar_valid_drop", rd_rsp_valid_out, 0);
    check("ar_data_drop", rd_rsp_data_out, 0);
    @(posedge clk_in);
    #2;
    reset_n_in      = 1'b1;
    rd_rsp_ready_in = 1'b1;
    #1;
    check("ar_no_stale0", rd_rsp_valid_out, 0);
    tick();
    check("ar_no_stale1", rd_rsp_valid_out, 0);
    tick();
    check("ar_no_stale2", rd_rsp_valid_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
